// File: rtl/ysyx_23060059_pkg.sv
// Shared NPC definitions: fetch FSM state encoding, AXI response codes and reset PC.
package ysyx_23060059_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_OUT  = 3'd3,
        S_WAIT = 3'd4
    } ifu_state_t;

    localparam logic [1:0]  AXI_RESP_OKAY          = 2'b00;
    localparam logic [31:0] YSYX_23060059_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_if.sv
// AXI4-Lite read channel between the fetch unit (master) and instruction memory (slave).
interface ifu_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one AXI read per retired instruction, then hands {inst, pc}
// downstream and waits for the next PC from write-back.
module ifu
    import ysyx_23060059_pkg::*;
#(
    parameter logic [31:0] RESET_PC = YSYX_23060059_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_if.master       axi,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_fault,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic        npc_ready
);

    ifu_state_t  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic        fault_reg, fault_next;
    logic        misaligned;

    assign misaligned = (pc_reg[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_PC;
            inst_reg  <= 32'h0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
            fault_reg <= fault_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        fault_next = fault_reg;
        case (state_reg)
            S_IDLE: state_next = S_AR;
            S_AR: begin
                // A misaligned PC never reaches the bus; it is reported as a faulting fetch.
                if (misaligned) begin
                    inst_next  = 32'h0;
                    fault_next = 1'b1;
                    state_next = S_OUT;
                end else if (axi.arready) begin
                    state_next = S_R;
                end
            end
            S_R: begin
                if (axi.rvalid) begin
                    inst_next  = axi.rdata;
                    fault_next = (axi.rresp != AXI_RESP_OKAY);
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (inst_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (npc_valid) begin
                    pc_next    = npc;
                    fault_next = 1'b0;
                    state_next = S_AR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs come straight from registered state so they are glitch-free.
    assign axi.araddr  = pc_reg;
    assign axi.arvalid = (state_reg == S_AR) && !misaligned;
    assign axi.rready  = (state_reg == S_R);
    assign inst_valid  = (state_reg == S_OUT);
    assign npc_ready   = (state_reg == S_WAIT);
    assign inst        = inst_reg;
    assign pc          = pc_reg;
    assign inst_fault  = fault_reg;

endmodule
